jelly2_rtos_event_capture: RTL

Upstream conditioner for the RTOS external flag input. It takes asynchronous event lines (pins, timer IRQs, PL IRQs), synchronises them, detects the selected edges, and applies a per-channel hold-off. Each qualified event becomes a one-cycle pulse on out_set_flg, which drives ext_set_flg of jelly2_rtos bit-for-bit. A Wishbone register slave on the peripheral bus provides enable, edge-select, pending/dropped status and software force.

---
 rtl/jelly2_rtos_event_pkg.sv | 13 +
 rtl/jelly2_rtos_event_capture_channel.sv | 67 ++++++
 rtl/jelly2_rtos_event_capture.sv | 113 +++++++++++
 3 files changed

// File: rtl/jelly2_rtos_event_pkg.sv
// jelly2_rtos_event_pkg: register map, core id and channel state for the RTOS event capture block
package jelly2_rtos_event_pkg;
  localparam int ADR_CORE_ID  = 0;
  localparam int ADR_ENABLE   = 1;
  localparam int ADR_RISE     = 2;
  localparam int ADR_FALL     = 3;
  localparam int ADR_PENDING  = 4;
  localparam int ADR_HOLDOFF  = 5;
  localparam int ADR_DROPPED  = 6;
  localparam int ADR_FORCE    = 7;
  localparam logic [31:0] CORE_ID = 32'h834f_e0c0;
  typedef enum logic {ST_IDLE, ST_HOLD} state_t;
endpackage

// File: rtl/jelly2_rtos_event_capture_channel.sv
// jelly2_rtos_event_channel: synchroniser, edge select, hold-off FSM and pulse register for one event line
module jelly2_rtos_event_channel
  import jelly2_rtos_event_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int HOLDOFF_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     i_event,
  input  logic                     i_arm,
  input  logic                     i_enable,
  input  logic                     i_rise,
  input  logic                     i_fall,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
  input  logic                     i_force,
  output logic                     o_pulse,
  output logic                     o_drop
);
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     r_prev;
  logic                     r_edge;
  logic                     r_pulse;
  state_t                   r_state;
  logic [HOLDOFF_WIDTH-1:0] r_cnt;
  state_t                   w_state_n;
  logic [HOLDOFF_WIDTH-1:0] w_cnt_n;
  logic                     w_sync;
  logic                     w_edge;
  logic                     w_hit;
  logic                     w_load;
  logic                     w_pulse_n;
  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_edge = i_arm & ((i_rise & w_sync & ~r_prev) | (i_fall & ~w_sync & r_prev));
  assign w_hit  = r_edge & i_enable;
  assign w_load = (r_state == ST_IDLE) & w_hit & (|i_holdoff);
  assign w_pulse_n = i_enable & (((r_state == ST_IDLE) & r_edge) | i_force);
  assign o_drop  = w_hit & (r_state == ST_HOLD);
  assign o_pulse = r_pulse;
  always_comb begin
    w_state_n = (r_state == ST_HOLD) ? ((r_cnt == HOLDOFF_WIDTH'(1)) ? ST_IDLE : ST_HOLD)
                                     : (w_load ? ST_HOLD : ST_IDLE);
    w_cnt_n   = (r_state == ST_HOLD) ? r_cnt - 1'b1 : (w_load ? i_holdoff : r_cnt);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_edge  <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_event};
      r_prev  <= w_sync;
      r_edge  <= w_edge;
      r_pulse <= w_pulse_n;
      r_cnt   <= w_cnt_n;
    end
  end
endmodule

// File: rtl/jelly2_rtos_event_capture.sv
// jelly2_rtos_event_capture: conditions async event lines into one-cycle RTOS set-flag pulses with a Wishbone register slave
module jelly2_rtos_event_capture
  import jelly2_rtos_event_pkg::*;
#(
  parameter int CHANNELS      = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int HOLDOFF_WIDTH = 8,
  parameter int WB_ADR_WIDTH  = 3,
  parameter int WB_DAT_WIDTH  = 32
) (
  input  logic                      aresetn,
  input  logic                      aclk,
  input  logic [CHANNELS-1:0]       in_event,
  input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
  input  logic                      s_wb_we_i,
  input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
  input  logic                      s_wb_stb_i,
  output logic                      s_wb_ack_o,
  output logic [CHANNELS-1:0]       out_set_flg,
  output logic                      irq
);
  localparam int WARM_WIDTH = $clog2(SYNC_STAGES + 2);
  logic [CHANNELS-1:0]      r_enable;
  logic [CHANNELS-1:0]      r_rise;
  logic [CHANNELS-1:0]      r_fall;
  logic [CHANNELS-1:0]      r_pending;
  logic [CHANNELS-1:0]      r_dropped;
  logic [HOLDOFF_WIDTH-1:0] r_holdoff;
  logic                     r_irq;
  logic [WARM_WIDTH-1:0]    r_warm;
  logic                     w_arm;
  logic                     w_we;
  logic [WB_DAT_WIDTH-1:0]  w_wm;
  logic [WB_DAT_WIDTH-1:0]  w_wd;
  logic                     w_wr_enable;
  logic                     w_wr_rise;
  logic                     w_wr_fall;
  logic                     w_wr_pending;
  logic                     w_wr_holdoff;
  logic                     w_wr_dropped;
  logic                     w_wr_force;
  logic [CHANNELS-1:0]      w_force;
  logic [CHANNELS-1:0]      w_pulse;
  logic [CHANNELS-1:0]      w_drop;
  for (genvar b = 0; b < WB_DAT_WIDTH / 8; b++) begin : g_sel
    assign w_wm[b*8 +: 8] = {8{s_wb_sel_i[b]}};
  end
  assign w_we         = s_wb_stb_i & s_wb_we_i;
  assign w_wd         = s_wb_dat_i & w_wm;
  assign w_wr_enable  = w_we & (s_wb_adr_i == WB_ADR_WIDTH'(ADR_ENABLE));
  assign w_wr_rise    = w_we & (s_wb_adr_i == WB_ADR_WIDTH'(ADR_RISE));
  assign w_wr_fall    = w_we & (s_wb_adr_i == WB_ADR_WIDTH'(ADR_FALL));
  assign w_wr_pending = w_we & (s_wb_adr_i == WB_ADR_WIDTH'(ADR_PENDING));
  assign w_wr_holdoff = w_we & (s_wb_adr_i == WB_ADR_WIDTH'(ADR_HOLDOFF));
  assign w_wr_dropped = w_we & (s_wb_adr_i == WB_ADR_WIDTH'(ADR_DROPPED));
  assign w_wr_force   = w_we & (s_wb_adr_i == WB_ADR_WIDTH'(ADR_FORCE));
  assign w_force      = {CHANNELS{w_wr_force}} & w_wd[CHANNELS-1:0];
  assign w_arm        = (r_warm == WARM_WIDTH'(SYNC_STAGES + 1));
  assign s_wb_ack_o   = s_wb_stb_i;
  assign out_set_flg  = w_pulse;
  assign irq          = r_irq;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    jelly2_rtos_event_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .HOLDOFF_WIDTH (HOLDOFF_WIDTH)
    ) u_ch (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .i_event   (in_event[i]),
      .i_arm     (w_arm),
      .i_enable  (r_enable[i]),
      .i_rise    (r_rise[i]),
      .i_fall    (r_fall[i]),
      .i_holdoff (r_holdoff),
      .i_force   (w_force[i]),
      .o_pulse   (w_pulse[i]),
      .o_drop    (w_drop[i])
    );
  end
  always_comb begin
    s_wb_dat_o = (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CORE_ID)) ? WB_DAT_WIDTH'(CORE_ID)   :
                 (s_wb_adr_i == WB_ADR_WIDTH'(ADR_ENABLE))  ? WB_DAT_WIDTH'(r_enable)  :
                 (s_wb_adr_i == WB_ADR_WIDTH'(ADR_RISE))    ? WB_DAT_WIDTH'(r_rise)    :
                 (s_wb_adr_i == WB_ADR_WIDTH'(ADR_FALL))    ? WB_DAT_WIDTH'(r_fall)    :
                 (s_wb_adr_i == WB_ADR_WIDTH'(ADR_PENDING)) ? WB_DAT_WIDTH'(r_pending) :
                 (s_wb_adr_i == WB_ADR_WIDTH'(ADR_HOLDOFF)) ? WB_DAT_WIDTH'(r_holdoff) :
                 (s_wb_adr_i == WB_ADR_WIDTH'(ADR_DROPPED)) ? WB_DAT_WIDTH'(r_dropped) :
                 '0;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_enable  <= '0;
      r_rise    <= '1;
      r_fall    <= '0;
      r_pending <= '0;
      r_dropped <= '0;
      r_holdoff <= '0;
      r_irq     <= 1'b0;
      r_warm    <= '0;
    end else begin
      r_enable  <= w_wr_enable  ? (r_enable  & ~w_wm[CHANNELS-1:0])      | w_wd[CHANNELS-1:0]      : r_enable;
      r_rise    <= w_wr_rise    ? (r_rise    & ~w_wm[CHANNELS-1:0])      | w_wd[CHANNELS-1:0]      : r_rise;
      r_fall    <= w_wr_fall    ? (r_fall    & ~w_wm[CHANNELS-1:0])      | w_wd[CHANNELS-1:0]      : r_fall;
      r_holdoff <= w_wr_holdoff ? (r_holdoff & ~w_wm[HOLDOFF_WIDTH-1:0]) | w_wd[HOLDOFF_WIDTH-1:0] : r_holdoff;
      r_pending <= (r_pending & ~({CHANNELS{w_wr_pending}} & w_wd[CHANNELS-1:0])) | w_pulse;
      r_dropped <= (r_dropped & ~({CHANNELS{w_wr_dropped}} & w_wd[CHANNELS-1:0])) | w_drop;
      r_irq     <= |r_pending;
      r_warm    <= w_arm ? r_warm : r_warm + 1'b1;
    end
  end
endmodule
